// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse cursor tracker.
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    CLAMP = 2'd2
  } state_t;

  // Raw PS/2 delta width ({sign, 8-bit magnitude}) and width after optional doubling.
  localparam int DELTA_W     = 9;
  localparam int ACC_DELTA_W = 10;

  // Home position on one axis: the middle of the visible range.
  function automatic int home_pos(input int res);
    return res / 2;
  endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Clamps one signed, unwrapped axis position into the visible range 0..LIMIT.
module mouse_axis_clamp
  import mouse_pkg::*;
#(
  parameter int IN_W    = 14,
  parameter int COORD_W = 11,
  parameter int LIMIT   = 639
) (
  input  logic signed [IN_W-1:0]    pos,
  output logic        [COORD_W-1:0] coord
);

  localparam logic signed [IN_W-1:0] LIMIT_S = IN_W'(LIMIT);

  // Saturate below zero and above the last visible pixel.
  always_comb begin
    coord = '0;
    if (pos[IN_W-1]) begin
      coord = '0;
    end else if (pos > LIMIT_S) begin
      coord = COORD_W'(LIMIT);
    end else begin
      coord = pos[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Cursor-position engine: accepts decoded PS/2 movement packets, applies
// saturated (and optionally accelerated) deltas, clamps to the screen and
// publishes registered coordinates, buttons and one-cycle event pulses.
// Optional feature macro: MOUSE_TRACKER_ACCEL_EN (delta doubling above ACCEL_THRESH).
module mouse_cursor_tracker
  import mouse_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int COORD_W      = 11,
  parameter int ACCEL_THRESH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic [7:0]         dx,
  input  logic [7:0]         dy,
  input  logic               sx,
  input  logic               sy,
  input  logic               ovx,
  input  logic               ovy,
  input  logic [2:0]         btn_in,
  input  logic               recenter,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [2:0]         btn,
  output logic [2:0]         click,
  output logic               upd
);

  // Three extra bits hold cursor + largest delta (either sign) without wrapping.
  localparam int SUM_W = COORD_W + 3;

  localparam logic [COORD_W-1:0] HOME_X = COORD_W'(home_pos(H_RES));
  localparam logic [COORD_W-1:0] HOME_Y = COORD_W'(home_pos(V_RES));

`ifdef MOUSE_TRACKER_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam logic [DELTA_W-1:0] THRESH = DELTA_W'(ACCEL_THRESH);

  // Overflow saturation first, then doubling of large deltas when enabled.
  function automatic logic signed [ACC_DELTA_W-1:0] shape_delta(
    input logic       s,
    input logic [7:0] mag,
    input logic       ov
  );
    logic signed [DELTA_W-1:0]     d;
    logic        [DELTA_W-1:0]     a;
    logic signed [ACC_DELTA_W-1:0] w;
    if (ov) begin
      d = s ? 9'h100 : 9'h0FF;
    end else begin
      d = {s, mag};
    end
    a = d[DELTA_W-1] ? $unsigned(-d) : $unsigned(d);
    w = ACC_DELTA_W'(d);
    if (ACCEL_ON && (a >= THRESH)) begin
      w = w <<< 1;
    end
    return w;
  endfunction

  state_t state;
  state_t state_nxt;
  logic   take;

  logic signed [ACC_DELTA_W-1:0] dlt_x;
  logic signed [ACC_DELTA_W-1:0] dlt_y;
  logic        [2:0]             btn_lat;
  logic signed [SUM_W-1:0]       nx;
  logic signed [SUM_W-1:0]       ny;
  logic        [COORD_W-1:0]     clamp_x;
  logic        [COORD_W-1:0]     clamp_y;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; recenter overrides any sequence in progress.
  always_comb begin
    state_nxt = state;
    if (recenter) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (take) state_nxt = SUM;
        SUM:     state_nxt = CLAMP;
        CLAMP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs: a packet is only taken in IDLE and never alongside recenter.
  always_comb begin
    pkt_ready = (state == IDLE) && !recenter;
    take      = pkt_valid && pkt_ready;
  end

  // Capture shaped deltas and button state on transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dlt_x   <= '0;
      dlt_y   <= '0;
      btn_lat <= '0;
    end else if (take) begin
      dlt_x   <= shape_delta(sx, dx, ovx);
      dlt_y   <= shape_delta(sy, dy, ovy);
      btn_lat <= btn_in;
    end
  end

  // Unclamped new position; PS/2 Y grows upward while screen Y grows downward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nx <= '0;
      ny <= '0;
    end else if (state == SUM) begin
      nx <= $signed({{(SUM_W-COORD_W){1'b0}}, cx}) + SUM_W'(dlt_x);
      ny <= $signed({{(SUM_W-COORD_W){1'b0}}, cy}) - SUM_W'(dlt_y);
    end
  end

  mouse_axis_clamp #(
    .IN_W   (SUM_W),
    .COORD_W(COORD_W),
    .LIMIT  (H_RES - 1)
  ) u_clamp_x (
    .pos  (nx),
    .coord(clamp_x)
  );

  mouse_axis_clamp #(
    .IN_W   (SUM_W),
    .COORD_W(COORD_W),
    .LIMIT  (V_RES - 1)
  ) u_clamp_y (
    .pos  (ny),
    .coord(clamp_y)
  );

  // Published outputs: pulses default low, rewritten on CLAMP or recenter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx    <= HOME_X;
      cy    <= HOME_Y;
      btn   <= '0;
      click <= '0;
      upd   <= 1'b0;
    end else begin
      upd   <= 1'b0;
      click <= '0;
      if (recenter) begin
        cx  <= HOME_X;
        cy  <= HOME_Y;
        upd <= 1'b1;
      end else if (state == CLAMP) begin
        cx    <= clamp_x;
        cy    <= clamp_y;
        btn   <= btn_lat;
        click <= btn_lat & ~btn;
        upd   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mouse_cursor_tracker.md
# mouse_cursor_tracker

Synchronous, parametrised cursor-position engine between the PS/2 mouse packet decoder and the VGA cursor overlay. Accepts decoded movement packets over a valid/ready handshake and applies 9-bit two's-complement deltas with overflow saturation and optional acceleration. Clamps the result to a configurable screen rectangle and publishes registered coordinates, button state and one-cycle event pulses. Supersedes the edge-triggered, fixed-640×480 cursor accumulator.

## Interface
- H_RES, 640: horizontal resolution; cx range 0..H_RES-1
- V_RES, 480: vertical resolution; cy range 0..V_RES-1
- COORD_W, 11: coordinate width; must satisfy 2^COORD_W ≥ max(H_RES, V_RES)
- ACCEL_THRESH, 16: |delta| at or above which acceleration applies (MOUSE_TRACKER_ACCEL_EN only)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- pkt_valid  in  1  packet present on dx/dy/sx/sy/ovx/ovy/btn_in
- pkt_ready  out  1  block can accept; transfer when pkt_valid & pkt_ready at clk edge
- dx, dy  in  8  delta magnitude bits; {sx,dx} / {sy,dy} form 9-bit two's complement
- sx, sy  in  1  delta sign bits
- ovx, ovy  in  1  PS/2 overflow flags
- btn_in  in  3  {middle, right, left} from packet
- recenter  in  1  synchronous request to home the cursor
- cx  out  COORD_W  cursor X, unsigned
- cy  out  COORD_W  cursor Y, unsigned, 0 = top
- btn  out  3  registered button state
- click  out  3  one-cycle pulse per button on 0→1 transition
- upd  out  1  one-cycle pulse when cx/cy/btn are rewritten

## Operation
- Reset values: cx = H_RES/2, cy = V_RES/2, btn = 0, click = 0, upd = 0, state IDLE, pkt_ready = 1.
- FSM: IDLE → SUM → CLAMP → IDLE. pkt_ready = (state == IDLE) & ~recenter.
- IDLE, transfer: latch deltas. ovx=1 forces X delta to +255 if sx=0, −256 if sx=1. ovy likewise for Y. Latch btn_in. Go to SUM.
- SUM: nx = cx + dX; ny = cy − dY (PS/2 Y is up-positive). Signed arithmetic at COORD_W+3 bits; no intermediate wrap. Go to CLAMP.
- CLAMP: nx < 0 → 0; nx > H_RES−1 → H_RES−1; Y identical against V_RES−1. Write cx, cy and btn. Pulse upd. click[i] = btn_latched[i] & ~btn[i]. Go to IDLE.
- recenter: in any state, next edge sets cx = H_RES/2, cy = V_RES/2, state IDLE, upd = 1. Any packet in flight is discarded. btn is unchanged, click = 0. No packet is accepted on that edge.
- Zero-delta packet still runs the full sequence and pulses upd.

## Timing
- Transfer at edge E0. SUM after E0, CLAMP after E1. cx/cy/btn/upd/click valid after E2. pkt_ready high again after E2.
- Throughput: one packet per 3 cycles. pkt_valid held while pkt_ready = 0 is not consumed and waits.
- upd and click are high for exactly one cycle.
- Reset asserted mid-sequence: immediate return to reset values; packet lost.

## Configuration
- MOUSE_TRACKER_ACCEL_EN defined: in IDLE, after saturation, a delta with |d| ≥ ACCEL_THRESH is doubled (range −512..+510). Applied per axis independently.
- Undefined: deltas are used 1:1. ACCEL_THRESH is ignored.

## Structure
- mouse_pkg: state enum (IDLE, SUM, CLAMP), DELTA_W = 9, ACC_DELTA_W = 10, and the home-position function.
- Sub-module mouse_axis_clamp (signed in, unsigned COORD_W out, parameter LIMIT), instantiated once per axis.

## Test plan
- Reset, then hold reset 3 cycles → cx = 320, cy = 240, btn = 0, pkt_ready = 1, upd = 0.
- Packet dx = 10, sx = 0, dy = 5, sy = 0 → after E2: cx = 330, cy = 235, upd one cycle; pkt_ready low for exactly 2 cycles.
- Clamp: from (320,240) send {sx,dx} = +255 twice, then ovx = 1 with sx = 1 → cx = 639, then cx = 639 − 256 = 383. Send dy = 255 three times → cy = 0.
- btn_in = 3'b001 then 3'b011 → click = 001 then 010, each for one cycle; btn tracks the packet values.
- recenter asserted during SUM of a dx = 50 packet → cx = 320, upd pulses, packet ignored. recenter together with pkt_valid → no transfer.
- MOUSE_TRACKER_ACCEL_EN defined: dx = 20 → cx += 40; dx = 15 → cx += 15. Macro undefined: dx = 20 → cx += 20.
